// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: default datapath width and the channel-count bound
// used by the stream arbiters.
package cpu_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAX_CH = 8;
endpackage

// File: rtl/rr_arb_mux_rr_pick.sv
// Combinational rotate-and-priority picker: first set request at or above ptr,
// wrapping from M-1 back to 0. Returns one-hot grant, its index and an any flag.
module rr_pick
    import cpu_pkg::*;
#(
    parameter int unsigned M  = 4,
    parameter int unsigned SW = $clog2(M)
) (
    input  logic [M-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [M-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    int unsigned k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        // Loop is bounded by MAX_CH so the unrolled search never exceeds the supported size.
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (i < M) begin
                k = (32'(ptr) + i) % M;
                if (!any && req[k]) begin
                    any    = 1'b1;
                    gnt[k] = 1'b1;
                    idx    = SW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin M:1 stream arbiter with a one-deep registered output stage.
// Optional macro RR_ARB_MUX_PRIO_EN gives channel 0 fixed top priority.
module rr_arb_mux
    import cpu_pkg::*;
#(
    parameter int unsigned N  = DATA_W,
    parameter int unsigned M  = 4,
    parameter int unsigned SW = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M-1:0]   in_valid,
    input  logic [M*N-1:0] in_data,
    output logic [M-1:0]   in_ready,
    output logic           out_valid,
    output logic [N-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load_en;
    logic [M-1:0]  rr_req, rr_gnt;
    logic [SW-1:0] rr_idx;
    logic          rr_any;
    logic [M-1:0]  pick_gnt;
    logic [SW-1:0] pick_idx;
    logic          pick_any;
    logic          pick_prio;
    logic [N-1:0]  sel_data;

    rr_pick #(.M(M), .SW(SW)) u_pick (
        .req (rr_req),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
`ifdef RR_ARB_MUX_PRIO_EN
        // Channel 0 bypasses the rotation; the ring only covers channels 1..M-1.
        rr_req    = {in_valid[M-1:1], 1'b0};
        pick_prio = in_valid[0];
`else
        rr_req    = in_valid;
        pick_prio = 1'b0;
`endif
        if (pick_prio) begin
            pick_gnt    = '0;
            pick_gnt[0] = 1'b1;
            pick_idx    = '0;
            pick_any    = 1'b1;
        end else begin
            pick_gnt = rr_gnt;
            pick_idx = rr_idx;
            pick_any = rr_any;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (pick_gnt[i]) sel_data = in_data[i*N +: N];
        end
    end

    assign load_en  = !out_valid_q || out_ready;
    // Reset is folded in so no channel sees a grant while the stage is held in reset.
    assign in_ready = (rst_n && load_en) ? pick_gnt : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (pick_any) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_sel_d   = pick_idx;
                if (!pick_prio) begin
                    ptr_d = (pick_idx == SW'(M-1)) ? '0 : pick_idx + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux at M=4, N=32.
// Builds with RR_ARB_MUX_PRIO_EN defined run the channel-0 priority sequence instead.
module tb_rr_arb_mux;

    localparam int unsigned N  = 32;
    localparam int unsigned M  = 4;
    localparam int unsigned SW = 2;

    logic           clk;
    logic           rst_n;
    logic [M-1:0]   in_valid;
    logic [M*N-1:0] in_data;
    logic [M-1:0]   in_ready;
    logic           out_valid;
    logic [N-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    rr_arb_mux #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".sel"}, 32'(out_sel), 32'(s));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
        step();
        step();
        chk_out("reset", 1'b0, 32'h0, 2'd0);
        chk("reset.in_ready", 32'(in_ready), 32'h0);

`ifdef RR_ARB_MUX_PRIO_EN
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        chk("prio.in_ready", 32'(in_ready), 32'b0001);
        for (int c = 0; c < 4; c++) begin
            step();
            chk_out("prio.ch0", 1'b1, 32'hA0, 2'd0);
        end
        in_valid = 4'b1110;
        step();
        chk_out("prio.rr1", 1'b1, 32'hA1, 2'd1);
        step();
        chk_out("prio.rr2", 1'b1, 32'hA2, 2'd2);
        step();
        chk_out("prio.rr3", 1'b1, 32'hA3, 2'd3);
`else
        // Rotation: all valid, sink always ready.
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        chk("rot.in_ready0", 32'(in_ready), 32'b0001);
        step();
        chk_out("rot0", 1'b1, 32'hA0, 2'd0);
        chk("rot.in_ready1", 32'(in_ready), 32'b0010);
        step();
        chk_out("rot1", 1'b1, 32'hA1, 2'd1);
        step();
        chk_out("rot2", 1'b1, 32'hA2, 2'd2);
        step();
        chk_out("rot3", 1'b1, 32'hA3, 2'd3);
        step();
        chk_out("rot4", 1'b1, 32'hA0, 2'd0);

        // Backpressure: ptr=1, so channel 1 carries 0x55 next.
        in_data[1*32 +: 32] = 32'h55;
        step();
        chk_out("bp.load", 1'b1, 32'h55, 2'd1);
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp.in_ready", 32'(in_ready), 32'h0);
            step();
            chk_out("bp.hold", 1'b1, 32'h55, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(in_ready), 32'b0100);
        step();
        chk_out("bp.next", 1'b1, 32'hA2, 2'd2);

        // Sparse wrap: ptr=3, only channel 1 valid.
        in_data[1*32 +: 32] = 32'hA1;
        in_valid = 4'b0010;
        #1;
        chk("wrap.in_ready", 32'(in_ready), 32'b0010);
        step();
        chk_out("wrap", 1'b1, 32'hA1, 2'd1);

        // Idle drain: output empties, data and select hold.
        in_valid = 4'b0000;
        #1;
        chk("drain.in_ready", 32'(in_ready), 32'h0);
        step();
        chk_out("drain", 1'b0, 32'hA1, 2'd1);
        step();
        chk_out("idle", 1'b0, 32'hA1, 2'd1);

        // ptr must be 2 after the wrap grant to channel 1.
        in_valid = 4'b1111;
        #1;
        chk("ptr2.in_ready", 32'(in_ready), 32'b0100);
        step();
        chk_out("ptr2", 1'b1, 32'hA2, 2'd2);

        // Mid-stream reset clears the held word without a clock edge.
        rst_n = 1'b0;
        #1;
        chk_out("midrst", 1'b0, 32'h0, 2'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post.in_ready", 32'(in_ready), 32'b0001);
        step();
        chk_out("post", 1'b1, 32'hA0, 2'd0);

        // Mixed pattern from ptr=1: channels 1 and 3 alternate.
        in_valid = 4'b1010;
        step();
        chk_out("mix1", 1'b1, 32'hA1, 2'd1);
        step();
        chk_out("mix3", 1'b1, 32'hA3, 2'd3);
        step();
        chk_out("mix1b", 1'b1, 32'hA1, 2'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
